// File: rtl/fourbit_recover.sv
// fourbit_recover: recovers the unknown addend B of an earlier addition
// {Cout,S} = A + B + Cin, computing B = {Cout,S} - A - Cin one slice per
// cycle with a ripple borrow. err flags a result that does not fit 64 bits.
//
// Build option: define FOURBIT_RECOVER_SLICE8_EN for 8-bit slices
// (8-cycle CALC, 3-bit counter); default is 4-bit slices (16-cycle CALC).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid          in_ready   request accepted when high
//   Cin, Cout  carry-in / carry-out of the original addition
//   S, A       sum and known addend of the original addition (64 bits)
//   out_valid  result valid           out_ready  consumer accepts result
//   B          recovered addend (low 64 bits of the 65-bit difference)
//   err        recovered value does not fit in 64 bits
module fourbit_recover (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Cin,
  input  logic        Cout,
  input  logic [63:0] S,
  input  logic [63:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] B,
  output logic        err
);

`ifdef FOURBIT_RECOVER_SLICE8_EN
  localparam int unsigned SLICE_W = 8;
  localparam int unsigned CNT_W   = 3;
`else
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned CNT_W   = 4;
`endif
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DIFF_W     = SLICE_W + 1;
  localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                borrow_q,    borrow_d;
  logic                cout_q,      cout_d;
  logic [DATA_W-1:0]   s_q,         s_d;
  logic [DATA_W-1:0]   a_q,         a_d;
  logic [DATA_W-1:0]   b_q,         b_d;
  logic                err_q,       err_d;
  logic                in_ready_q,  in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [DIFF_W-1:0]   diff;
  logic                last_slice;

  // Operands shift right each CALC cycle, so slice k always sits in the low
  // bits; results enter B from the top and reach B[k] after the final shift.
  assign diff = {1'b0, s_q[SLICE_W-1:0]} - {1'b0, a_q[SLICE_W-1:0]}
              - DIFF_W'(borrow_q);
  assign last_slice = (cnt_q == CNT_W'(NUM_SLICES - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      cout_q      <= 1'b0;
      s_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      cout_q      <= cout_d;
      s_q         <= s_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    cout_d      = cout_q;
    s_d         = s_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = CALC;
          cnt_d      = '0;
          borrow_d   = Cin;
          cout_d     = Cout;
          s_d        = S;
          a_d        = A;
          in_ready_d = 1'b0;
        end
      end

      CALC: begin
        s_d      = s_q >> SLICE_W;
        a_d      = a_q >> SLICE_W;
        b_d      = {diff[SLICE_W-1:0], b_q[DATA_W-1:SLICE_W]};
        borrow_d = diff[SLICE_W];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_slice) begin
          // Fits in 64 bits only when the final borrow cancels Cout exactly.
          state_d     = DONE;
          err_d       = cout_q ^ diff[SLICE_W];
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign B         = b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fourbit_recover.sv
// Scoreboard bench for fourbit_recover: accepted requests push a 65-bit
// arithmetic reference result; a negedge monitor compares every presented
// result, its latency, and its stability under backpressure.
module tb_fourbit_recover;

`ifdef FOURBIT_RECOVER_SLICE8_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        Cin = 1'b0;
  logic        Cout = 1'b0;
  logic [63:0] S = '0;
  logic [63:0] A = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] B;
  logic        err;

  typedef struct {
    logic [63:0] b;
    logic        err;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   n_done   = 0;
  int   n_abort  = 0;

  fourbit_recover dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Cin       (Cin),
    .Cout      (Cout),
    .S         (S),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .B         (B),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: full-width arithmetic; bit 65 = negative, bit 64 = too large.
  function automatic exp_t model(logic co, logic [63:0] s, logic [63:0] a,
                                 logic ci, int acc);
    exp_t m;
    logic [65:0] t;
    t      = {1'b0, co, s} - {2'b00, a} - 66'(ci);
    m.b    = t[63:0];
    m.err  = t[65] | t[64];
    m.acc  = acc;
    m.seen = 1'b0;
    return m;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record accepted requests at the sampling edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(Cout, S, A, Cin, cyc));
      n_acc++;
    end
  end

  // A reset aborts whatever was in flight.
  always @(posedge rst) begin
    n_abort += exp_q.size();
    exp_q.delete();
  end

  // Output monitor.
  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
    if (exp_q.size() > 0 && !exp_q[0].seen && (cyc - exp_q[0].acc) >= LAT)
      check("late_out_valid", 64'(out_valid), 64'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("B", B, exp_q[0].b);
        check("err", 64'(err), 64'(exp_q[0].err));
        if (!exp_q[0].seen) begin
          check("latency", 64'(cyc - exp_q[0].acc), 64'(LAT));
          exp_q[0].seen = 1'b1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_done++;
        end
      end
    end
  end

  task automatic send(logic co, logic [63:0] s, logic [63:0] a, logic ci);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready_timeout", 64'(in_ready), 64'd1);
    Cout = co; S = s; A = a; Cin = ci;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_B"},         B,              64'd0);
    check({tag, "_err"},       64'(err),       64'd0);
  endtask

  initial begin
    int n;
    int acc0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    tick();
    tick();

    // Vector 1, presented on the first edge after reset release.
    rst = 1'b0;
    Cout = 1'b0; S = 64'd5; A = 64'd3; Cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("accept_after_rst", 64'(n_acc), 64'd1);
    drain(40);
    check("vec1_B", B, 64'd2);
    check("vec1_err", 64'(err), 64'd0);

    // Vector 2: borrow ripples through every slice.
    send(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain(40);
    check("vec2_B", B, 64'd0);
    check("vec2_err", 64'(err), 64'd0);

    // Vector 3: negative result.
    send(1'b0, 64'd1, 64'd2, 1'b0);
    drain(40);
    check("vec3_B", B, 64'hFFFF_FFFF_FFFF_FFFF);
    check("vec3_err", 64'(err), 64'd1);

    // Backpressure hold with an ignored request during DONE.
    out_ready = 1'b0;
    acc0 = n_acc;
    send(1'b0, 64'd100, 64'd58, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("hold_out_valid_timeout", 64'(out_valid), 64'd1);
    repeat (5) begin
      in_valid = 1'b1;
      Cout = 1'($urandom_range(0, 1));
      S = {$urandom(), $urandom()};
      A = {$urandom(), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    check("hold_B", B, 64'd41);
    out_ready = 1'b1;
    drain(10);
    check("hold_one_accept", 64'(n_acc - acc0), 64'd1);

    // Reset mid-CALC aborts the operation.
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    #1 check_reset_outputs("midcalc_rst");
    tick();
    rst = 1'b0;
    send(1'b0, 64'd10, 64'd0, 1'b0);
    drain(40);
    check("after_rst_B", B, 64'd10);
    check("after_rst_err", 64'(err), 64'd0);

    // Randomised traffic with random backpressure and busy-time requests.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Cin  = 1'($urandom_range(0, 1));
      Cout = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin S = {$urandom(), $urandom()}; A = {$urandom(), $urandom()}; end
        1: begin A = {$urandom(), $urandom()}; S = A + 64'($urandom_range(0, 2)); end
        2: begin S = 64'd0; A = 64'hFFFF_FFFF_FFFF_FFFF; end
        default: begin S = 64'hFFFF_FFFF_FFFF_FFFF; A = 64'($urandom_range(0, 3)); end
      endcase
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(60);

    check("done_count", 64'(n_done), 64'(n_acc - n_abort));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
